uart2wb_ctrl: RTL

Command sequencer between the UART RX/TX byte FIFOs and a 32-bit Wishbone classic master port. It pops command bytes from the RX FIFO, assembles address and data, and runs one Wishbone cycle per command. It then pushes response bytes into the TX FIFO. Both FIFOs are edge-triggered on push/pop and expose combinational head data and empty/full flags.

---
 rtl/uart2wb_pkg.sv | 21 ++
 rtl/uart2wb_strobe_pacer.sv | 33 +++
 rtl/uart2wb_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart2wb_pkg.sv
// uart2wb_pkg -- shared constants and types for the UART-to-Wishbone bridge.
//   CMD_*  : command bytes accepted from the RX FIFO
//   RSP_*  : single-byte status responses pushed to the TX FIFO
//   state_t: sequencer states
package uart2wb_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h3F;  // '?'
  localparam logic [7:0] RSP_TMO = 8'h54;  // 'T'

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_BUS   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/uart2wb_strobe_pacer.sv
// uart2wb_strobe_pacer -- turns a level request into single-cycle strobes
// separated by at least one low cycle.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_req          : request (level)
//   o_fire         : combinational; high in the cycle whose closing edge raises the strobe
//   o_strobe       : registered one-cycle strobe
module uart2wb_strobe_pacer (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_req,
  output logic o_fire,
  output logic o_strobe
);

  logic r_strobe;

  // A request is only honoured while the strobe is low, which forces the gap.
  always_comb begin
    o_fire = i_req & ~r_strobe;
  end

  // Strobe register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= o_fire;
    end
  end

  assign o_strobe = r_strobe;

endmodule

// File: rtl/uart2wb_ctrl.sv
// uart2wb_ctrl -- command sequencer between UART RX/TX byte FIFOs and a
// 32-bit Wishbone classic master.
//   Frame: cmd, adr[31:24..7:0], and for 'W' dat[31:24..7:0].
//   Response: 'K' for write, 4 read bytes MSB first, '?' for bad cmd,
//             'T' on bus timeout (only when UART2WB_TIMEOUT_EN is defined).
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_rx_dat, i_rx_empty    : RX FIFO head byte / empty flag
//   o_rx_pop                : RX FIFO pop strobe
//   o_tx_dat, o_tx_push     : byte and push strobe to the TX FIFO
//   i_tx_full               : TX FIFO full flag
//   o_wb_*, i_wb_*          : Wishbone classic master port
//   o_busy                  : high whenever the sequencer is not idle
// Configuration macro: UART2WB_TIMEOUT_EN enables the ack-wait timeout
// bounded by TIMEOUT_CYCLES.
module uart2wb_ctrl
  import uart2wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_dat,
  input  logic        i_rx_empty,
  output logic        o_rx_pop,
  output logic [7:0]  o_tx_dat,
  input  logic        i_tx_full,
  output logic        o_tx_push,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  output logic        o_busy
);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic        r_we, w_we_nxt;
  logic [31:0] r_adr, w_adr_nxt;
  logic [31:0] r_wdat, w_wdat_nxt;
  logic [31:0] r_resp, w_resp_nxt;
  logic        r_cyc, w_cyc_nxt;
  logic        r_wb_we;
  logic [7:0]  r_tx_dat, w_tx_dat_nxt;
  logic        r_busy;

  logic        w_rx_req, w_rx_fire;
  logic        w_tx_req, w_tx_fire;

`ifdef UART2WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo, w_tmo_nxt;
`else
  // The limit only matters when the timeout feature is built in.
  logic w_unused_tmo;
  assign w_unused_tmo = |TIMEOUT_CYCLES;
`endif

  // Byte fetch is requested only in the three receiving states.
  always_comb begin
    w_rx_req = ((r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_WDATA))
               && !i_rx_empty;
    w_tx_req = (r_state == S_RESP) && !i_tx_full;
  end

  uart2wb_strobe_pacer u_rx_pacer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_req    (w_rx_req),
    .o_fire   (w_rx_fire),
    .o_strobe (o_rx_pop)
  );

  uart2wb_strobe_pacer u_tx_pacer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_req    (w_tx_req),
    .o_fire   (w_tx_fire),
    .o_strobe (o_tx_push)
  );

  // Next-state and datapath logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_we_nxt     = r_we;
    w_adr_nxt    = r_adr;
    w_wdat_nxt   = r_wdat;
    w_resp_nxt   = r_resp;
    w_cyc_nxt    = r_cyc;
    w_tx_dat_nxt = r_tx_dat;
`ifdef UART2WB_TIMEOUT_EN
    // Counter sits at zero outside S_BUS, so it is clear on entry.
    if (r_state == S_BUS) begin
      w_tmo_nxt = r_tmo + TW'(1);
    end else begin
      w_tmo_nxt = {TW{1'b0}};
    end
`endif
    case (r_state)
      S_IDLE: begin
        if (w_rx_fire) begin
          if ((i_rx_dat == CMD_WR) || (i_rx_dat == CMD_RD)) begin
            w_we_nxt    = (i_rx_dat == CMD_WR);
            w_cnt_nxt   = 2'd0;
            w_state_nxt = S_ADDR;
          end else begin
            // Counter preset to 3 so a single push wraps and exits.
            w_resp_nxt  = {RSP_ERR, 24'h000000};
            w_cnt_nxt   = 2'd3;
            w_state_nxt = S_RESP;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ADDR: begin
        if (w_rx_fire) begin
          w_adr_nxt = {r_adr[23:0], i_rx_dat};
          w_cnt_nxt = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            w_state_nxt = r_we ? S_WDATA : S_BUS;
            w_cyc_nxt   = !r_we;
          end else begin
            w_state_nxt = S_ADDR;
          end
        end else begin
          w_state_nxt = S_ADDR;
        end
      end
      S_WDATA: begin
        if (w_rx_fire) begin
          w_wdat_nxt = {r_wdat[23:0], i_rx_dat};
          w_cnt_nxt  = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            w_state_nxt = S_BUS;
            w_cyc_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_WDATA;
          end
        end else begin
          w_state_nxt = S_WDATA;
        end
      end
      S_BUS: begin
        if (i_wb_ack) begin
          w_cyc_nxt   = 1'b0;
          w_resp_nxt  = r_we ? {RSP_ACK, 24'h000000} : i_wb_dat;
          w_cnt_nxt   = r_we ? 2'd3 : 2'd0;
          w_state_nxt = S_RESP;
`ifdef UART2WB_TIMEOUT_EN
        end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          // This is the limit-th cycle without ack.
          w_cyc_nxt   = 1'b0;
          w_resp_nxt  = {RSP_TMO, 24'h000000};
          w_cnt_nxt   = 2'd3;
          w_state_nxt = S_RESP;
`endif
        end else begin
          w_state_nxt = S_BUS;
        end
      end
      S_RESP: begin
        if (w_tx_fire) begin
          w_tx_dat_nxt = r_resp[31:24];
          w_resp_nxt   = {r_resp[23:0], 8'h00};
          w_cnt_nxt    = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_RESP;
          end
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cyc_nxt   = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 2'd0;
      r_we     <= 1'b0;
      r_adr    <= 32'h00000000;
      r_wdat   <= 32'h00000000;
      r_resp   <= 32'h00000000;
      r_cyc    <= 1'b0;
      r_wb_we  <= 1'b0;
      r_tx_dat <= 8'h00;
      r_busy   <= 1'b0;
`ifdef UART2WB_TIMEOUT_EN
      r_tmo    <= {TW{1'b0}};
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_we     <= w_we_nxt;
      r_adr    <= w_adr_nxt;
      r_wdat   <= w_wdat_nxt;
      r_resp   <= w_resp_nxt;
      r_cyc    <= w_cyc_nxt;
      r_wb_we  <= w_cyc_nxt & w_we_nxt;
      r_tx_dat <= w_tx_dat_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
`ifdef UART2WB_TIMEOUT_EN
      r_tmo    <= w_tmo_nxt;
`endif
    end
  end

  assign o_wb_cyc = r_cyc;
  assign o_wb_stb = r_cyc;
  assign o_wb_we  = r_wb_we;
  assign o_wb_adr = r_adr;
  assign o_wb_dat = r_wdat;
  assign o_wb_sel = 4'hF;
  assign o_tx_dat = r_tx_dat;
  assign o_busy   = r_busy;

endmodule
